// File: rtl/player_ctrl.sv
// Per-player motion/jump/kick controller; state advances once per frame on frame_tick.
// Latency: one clk after the frame_tick edge; no backpressure, outputs hold between ticks.
module player_ctrl #(
    parameter int START_X       = 100,
    parameter int GROUND_Y      = 380,
    parameter int P_WIDTH       = 40,
    parameter int P_HEIGHT      = 100,
    parameter int X_MAX         = 600,
    parameter int SPEED         = 4,
    parameter int JUMP_HEIGHT   = 120,
    parameter int JUMP_SPEED    = 6,
    parameter int KICK_W        = 20,
    parameter int KICK_H        = 20,
    parameter int KICK_Y_OFF    = 40,
    parameter int KICK_FRAMES   = 8,
    parameter int KICK_COOLDOWN = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_jump,
    input  logic       btn_kick,
    output logic [9:0] xpos,
    output logic [9:0] ypos,
    output logic [9:0] width,
    output logic [9:0] height,
    output logic       facing,
    output logic       kick_active,
    output logic [9:0] kick_xpos,
    output logic [9:0] kick_ypos,
    output logic [9:0] kick_w,
    output logic [9:0] kick_h
);

    localparam int CNT_MAX = (KICK_FRAMES > KICK_COOLDOWN) ? KICK_FRAMES : KICK_COOLDOWN;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [10:0] SPD11  = 11'(SPEED);
    localparam logic [10:0] XMAX11 = 11'(X_MAX);
    localparam logic [10:0] JS11   = 11'(JUMP_SPEED);
    localparam logic [10:0] APEX11 = 11'(GROUND_Y - JUMP_HEIGHT);
    localparam logic [10:0] GY11   = 11'(GROUND_Y);
    localparam logic [10:0] PW11   = 11'(P_WIDTH);
    localparam logic [10:0] KW11   = 11'(KICK_W);
    localparam logic [10:0] KYO11  = 11'(KICK_Y_OFF);

    typedef enum logic [1:0] {V_GROUND, V_RISE, V_FALL} vstate_t;
    typedef enum logic [1:0] {K_READY, K_ACTIVE, K_COOLDOWN} kstate_t;

    vstate_t         vstate, vstate_n;
    kstate_t         kstate, kstate_n;
    logic [CW-1:0]   kcnt, kcnt_n;
    logic            kick_prev;
    logic [9:0]      xpos_n, ypos_n;
    logic            facing_n;

    // 11-bit arithmetic keeps the clamps free of wrap-around
    logic [10:0] x11, y11, x_left, x_right, y_up, y_dn;
    logic        kick_req;

    assign x11      = {1'b0, xpos};
    assign y11      = {1'b0, ypos};
    assign x_left   = (x11 < SPD11) ? 11'd0 : x11 - SPD11;
    assign x_right  = x11 + SPD11;
    assign y_up     = (y11 < JS11) ? 11'd0 : y11 - JS11;
    assign y_dn     = y11 + JS11;
    assign kick_req = btn_kick & ~kick_prev;

    always_comb begin
        xpos_n   = xpos;
        facing_n = facing;
        ypos_n   = ypos;
        vstate_n = vstate;
        kstate_n = kstate;
        kcnt_n   = kcnt;

        if (btn_left && !btn_right) begin
            xpos_n   = x_left[9:0];
            facing_n = 1'b0;
        end else if (btn_right && !btn_left) begin
            xpos_n   = (x_right > XMAX11) ? XMAX11[9:0] : x_right[9:0];
            facing_n = 1'b1;
        end

        case (vstate)
            V_GROUND: if (btn_jump) vstate_n = V_RISE;
            V_RISE: begin
                if (y_up <= APEX11) begin
                    ypos_n   = APEX11[9:0];
                    vstate_n = V_FALL;
                end else begin
                    ypos_n = y_up[9:0];
                end
            end
            V_FALL: begin
                if (y_dn >= GY11) begin
                    ypos_n   = GY11[9:0];
                    vstate_n = V_GROUND;
                end else begin
                    ypos_n = y_dn[9:0];
                end
            end
            default: vstate_n = V_GROUND;
        endcase

        // requests outside READY are dropped, never queued
        case (kstate)
            K_READY: begin
                if (kick_req) begin
                    kstate_n = K_ACTIVE;
                    kcnt_n   = CW'(KICK_FRAMES - 1);
                end
            end
            K_ACTIVE: begin
                if (kcnt == '0) begin
                    kstate_n = K_COOLDOWN;
                    kcnt_n   = CW'(KICK_COOLDOWN - 1);
                end else begin
                    kcnt_n = kcnt - 1'b1;
                end
            end
            K_COOLDOWN: begin
                if (kcnt == '0) kstate_n = K_READY;
                else            kcnt_n   = kcnt - 1'b1;
            end
            default: kstate_n = K_READY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xpos      <= 10'(START_X);
            ypos      <= 10'(GROUND_Y);
            facing    <= 1'b1;
            vstate    <= V_GROUND;
            kstate    <= K_READY;
            kcnt      <= '0;
            kick_prev <= 1'b0;
        end else if (frame_tick) begin
            xpos      <= xpos_n;
            ypos      <= ypos_n;
            facing    <= facing_n;
            vstate    <= vstate_n;
            kstate    <= kstate_n;
            kcnt      <= kcnt_n;
            kick_prev <= btn_kick;
        end
    end

    logic [10:0] kx_fwd, kx_back, ky11;
    assign kx_fwd  = x11 + PW11;
    assign kx_back = (x11 < KW11) ? 11'd0 : x11 - KW11;
    assign ky11    = y11 + KYO11;

    assign kick_active = (kstate == K_ACTIVE);
    assign kick_xpos   = facing ? kx_fwd[9:0] : kx_back[9:0];
    assign kick_ypos   = ky11[9:0];
    assign width       = 10'(P_WIDTH);
    assign height      = 10'(P_HEIGHT);
    assign kick_w      = 10'(KICK_W);
    assign kick_h      = 10'(KICK_H);

endmodule

// File: tb/tb_player_ctrl.sv
// Self-checking bench for player_ctrl: vector table and loops through a scoreboard queue,
// plus hand-written clamp, kick-box and async-reset sequences.
module tb_player_ctrl;

    logic clk = 1'b0;
    logic rst, frame_tick, btn_left, btn_right, btn_jump, btn_kick;

    logic [9:0] xpos, ypos, width, height, kick_xpos, kick_ypos, kick_w, kick_h;
    logic       facing, kick_active;
    logic [9:0] xo, yo, wo, ho, kxo, kyo, kwo, kho;
    logic       fo, kao;

    always #5 clk = ~clk;

    player_ctrl u_dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick),
        .btn_left(btn_left), .btn_right(btn_right), .btn_jump(btn_jump), .btn_kick(btn_kick),
        .xpos(xpos), .ypos(ypos), .width(width), .height(height), .facing(facing),
        .kick_active(kick_active), .kick_xpos(kick_xpos), .kick_ypos(kick_ypos),
        .kick_w(kick_w), .kick_h(kick_h)
    );

    // second instance starting at an odd-aligned x so the clamps land off the SPEED grid
    player_ctrl #(.START_X(2)) u_odd (
        .clk(clk), .rst(rst), .frame_tick(frame_tick),
        .btn_left(btn_left), .btn_right(btn_right), .btn_jump(btn_jump), .btn_kick(btn_kick),
        .xpos(xo), .ypos(yo), .width(wo), .height(ho), .facing(fo),
        .kick_active(kao), .kick_xpos(kxo), .kick_ypos(kyo),
        .kick_w(kwo), .kick_h(kho)
    );

    typedef struct {
        logic l, r, j, k;
        int   x, y;
        logic f, ka;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    vec_t sbq[$];
    vec_t vecs[10];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic frame(input logic l, input logic r, input logic j, input logic k);
        @(posedge clk); #1;
        btn_left = l; btn_right = r; btn_jump = j; btn_kick = k;
        frame_tick = 1'b1;
        @(posedge clk); #1;
        frame_tick = 1'b0;
    endtask

    task automatic step(input vec_t v, input string tag);
        vec_t e;
        sbq.push_back(v);
        frame(v.l, v.r, v.j, v.k);
        if (sbq.size() == 0) begin
            chk({tag, " queue"}, 0, 1);
        end else begin
            e = sbq.pop_front();
            chk({tag, " xpos"},   int'(xpos),        e.x);
            chk({tag, " ypos"},   int'(ypos),        e.y);
            chk({tag, " facing"}, int'(facing),      int'(e.f));
            chk({tag, " kick"},   int'(kick_active), int'(e.ka));
        end
    endtask

    task automatic do_reset();
        frame_tick = 1'b0;
        btn_left = 1'b0; btn_right = 1'b0; btn_jump = 1'b0; btn_kick = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin : main
        vec_t v;
        int   ey;
        logic eka, kb;
        int   changes;
        logic [9:0] x0, y0, kx0, ky0;
        logic f0, ka0;

        rst = 1'b1;
        frame_tick = 1'b0;
        btn_left = 1'b0; btn_right = 1'b0; btn_jump = 1'b0; btn_kick = 1'b0;

        vecs[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 104, 380, 1'b1, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 108, 380, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 112, 380, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 116, 380, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 120, 380, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 120, 380, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 120, 380, 1'b1, 1'b0};
        vecs[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 116, 380, 1'b0, 1'b0};
        vecs[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 116, 380, 1'b0, 1'b0};
        vecs[9] = '{1'b0, 1'b1, 1'b0, 1'b0, 120, 380, 1'b1, 1'b0};

        // reset state and constant outputs
        do_reset();
        chk("reset xpos",   int'(xpos),        100);
        chk("reset ypos",   int'(ypos),        380);
        chk("reset facing", int'(facing),      1);
        chk("reset kick",   int'(kick_active), 0);
        chk("width",        int'(width),       40);
        chk("height",       int'(height),      100);
        chk("kick_w",       int'(kick_w),      20);
        chk("kick_h",       int'(kick_h),      20);

        // horizontal motion table
        for (int i = 0; i < 10; i++) step(vecs[i], $sformatf("move v%0d", i));

        // x clamps on the odd-aligned instance
        do_reset();
        for (int i = 0; i < 149; i++) frame(1'b0, 1'b1, 1'b0, 1'b0);
        chk("odd x 598", int'(xo), 598);
        frame(1'b0, 1'b1, 1'b0, 1'b0);
        chk("odd x clamp max", int'(xo), 600);
        frame(1'b0, 1'b1, 1'b0, 1'b0);
        chk("odd x hold max", int'(xo), 600);
        do_reset();
        frame(1'b1, 1'b0, 1'b0, 1'b0);
        chk("odd x clamp 0", int'(xo), 0);
        chk("odd facing left", int'(fo), 0);
        frame(1'b1, 1'b0, 1'b0, 1'b0);
        chk("odd x hold 0", int'(xo), 0);

        // jump arc, mid-air presses ignored, held-jump re-launch after landing
        do_reset();
        for (int k = 1; k <= 44; k++) begin
            if (k <= 21)      ey = 380 - 6 * (k - 1);
            else if (k <= 41) ey = 260 + 6 * (k - 21);
            else if (k <= 43) ey = 380;
            else              ey = 374;
            v = '{1'b0, 1'b0, (k == 1 || k == 10 || k == 30 || k == 43), 1'b0,
                  100, ey, 1'b1, 1'b0};
            step(v, $sformatf("jump t%0d", k));
        end

        // kick: held press, release/re-press, press during cooldown
        do_reset();
        for (int k = 1; k <= 60; k++) begin
            kb  = (k <= 30) || (k == 32) || (k == 42) || (k == 58);
            eka = (k <= 8) || (k >= 32 && k <= 39) || (k >= 58);
            v = '{1'b0, 1'b0, 1'b0, kb, 100, 380, 1'b1, eka};
            step(v, $sformatf("kick t%0d", k));
        end

        // kick box facing left near the wall
        do_reset();
        repeat (3) frame(1'b0, 1'b1, 1'b0, 1'b0);
        frame(1'b1, 1'b0, 1'b0, 1'b1);
        chk("odd kick x", int'(xo), 10);
        chk("odd kick active", int'(kao), 1);
        chk("kick_xpos clamp 0", int'(kxo), 0);
        chk("kick_ypos odd", int'(kyo), 420);

        // kick box tracking while jumping, then async reset mid-RISE with kick active
        do_reset();
        step('{1'b0, 1'b0, 1'b1, 1'b1, 100, 380, 1'b1, 1'b1}, "kj t1");
        chk("kick_xpos right", int'(kick_xpos), 140);
        chk("kick_ypos ground", int'(kick_ypos), 420);
        step('{1'b1, 1'b0, 1'b0, 1'b1, 96, 374, 1'b0, 1'b1}, "kj t2");
        chk("kick_xpos left", int'(kick_xpos), 76);
        chk("kick_ypos rise", int'(kick_ypos), 414);
        step('{1'b0, 1'b0, 1'b0, 1'b0, 96, 368, 1'b0, 1'b1}, "kj t3");

        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("async rst xpos",   int'(xpos),        100);
        chk("async rst ypos",   int'(ypos),        380);
        chk("async rst facing", int'(facing),      1);
        chk("async rst kick",   int'(kick_active), 0);
        chk("async rst kick_x", int'(kick_xpos),   140);
        @(posedge clk); #1;
        rst = 1'b0;

        // no frame_tick: nothing moves despite button activity
        x0 = xpos; y0 = ypos; f0 = facing; ka0 = kick_active; kx0 = kick_xpos; ky0 = kick_ypos;
        changes = 0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk); #1;
            btn_left  = 1'($urandom_range(0, 1));
            btn_right = 1'($urandom_range(0, 1));
            btn_jump  = 1'($urandom_range(0, 1));
            btn_kick  = 1'($urandom_range(0, 1));
            if (xpos != x0 || ypos != y0 || facing != f0 || kick_active != ka0 ||
                kick_xpos != kx0 || kick_ypos != ky0)
                changes++;
        end
        chk("idle output changes", changes, 0);
        chk("idle xpos", int'(xpos), 100);

        // vertical FSM really returned to GROUND: no further rise
        step('{1'b0, 1'b0, 1'b0, 1'b0, 100, 380, 1'b1, 1'b0}, "post rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/player_ctrl.md
Name: player_ctrl

Overview:
- Per-player motion and kick controller for the VGA fighting game.
- Sits directly upstream of the box-hit comparators. It produces the player box (xpos, ypos, width, height) and the kick box (kick_xpos, kick_ypos, kick_w, kick_h) that feed those comparators.
- All state advances only once per frame, on frame_tick, so positions never change mid-scan.
- One instance is used per player.

Parameters:
- START_X, 100, reset xpos
- GROUND_Y, 380, ypos when standing
- P_WIDTH, 40, player box width
- P_HEIGHT, 100, player box height
- X_MAX, 600, largest legal xpos (X_MAX + P_WIDTH <= 640)
- SPEED, 4, horizontal pixels per frame
- JUMP_HEIGHT, 120, apex = GROUND_Y - JUMP_HEIGHT
- JUMP_SPEED, 6, vertical pixels per frame
- KICK_W, 20, kick box width
- KICK_H, 20, kick box height
- KICK_Y_OFF, 40, kick box offset below ypos
- KICK_FRAMES, 8, frames the kick box stays active
- KICK_COOLDOWN, 16, frames after a kick before the next kick can start

Ports:
- clk, in, 1, pixel clock
- rst, in, 1, asynchronous active-high reset
- frame_tick, in, 1, one-clk pulse once per frame (start of vertical blank)
- btn_left, in, 1, level, already synchronised
- btn_right, in, 1, level, already synchronised
- btn_jump, in, 1, level, already synchronised
- btn_kick, in, 1, level, already synchronised
- xpos, out, 10, player box left edge
- ypos, out, 10, player box top edge
- width, out, 10, constant P_WIDTH
- height, out, 10, constant P_HEIGHT
- facing, out, 1, 1 = right, 0 = left
- kick_active, out, 1, kick box valid
- kick_xpos, out, 10, kick box left edge
- kick_ypos, out, 10, kick box top edge
- kick_w, out, 10, constant KICK_W
- kick_h, out, 10, constant KICK_H

Behaviour:
Reset (asynchronous, on rst high):
- xpos = START_X, ypos = GROUND_Y, facing = 1.
- Vertical FSM = GROUND, kick FSM = READY, kick_active = 0, kick counter = 0, kick_prev = 0.

General timing:
- All registers update only on a clk edge where frame_tick = 1. Buttons are sampled on that same edge.
- New outputs are visible one clk after the frame_tick edge. With no frame_tick, every output holds.

Horizontal motion:
- left only: xpos = (xpos < SPEED) ? 0 : xpos - SPEED; facing = 0.
- right only: xpos = (xpos + SPEED > X_MAX) ? X_MAX : xpos + SPEED; facing = 1.
- Both or neither pressed: xpos and facing hold.
- Compute in 11 bits so there is no wrap-around.
- Horizontal motion is allowed in every vertical state.

Vertical FSM:
- GROUND: if btn_jump, go to RISE. ypos does not change on this tick.
- RISE: ypos -= JUMP_SPEED. If the result <= apex, ypos = apex and go to FALL.
- FALL: ypos += JUMP_SPEED. If the result >= GROUND_Y, ypos = GROUND_Y and go to GROUND.
- btn_jump is ignored in RISE and FALL. Holding it in GROUND re-jumps on the next tick after landing.

Kick FSM:
- A kick request is a frame-sampled rising edge: btn_kick = 1 and kick_prev = 0. kick_prev <= btn_kick on every frame_tick.
- READY: on a request, go to ACTIVE, counter = KICK_FRAMES - 1, kick_active = 1.
- ACTIVE: counter decrements each tick. When it reaches 0 on a tick, go to COOLDOWN with counter = KICK_COOLDOWN - 1 and kick_active = 0. The kick is therefore active for exactly KICK_FRAMES frames.
- COOLDOWN: counter decrements; at 0, go to READY. Requests in ACTIVE or COOLDOWN are discarded, not queued.
- A held btn_kick never retriggers; it must be released for at least one frame first.

Kick box position (combinational from registered state, for the current frame):
- facing = 1: kick_xpos = xpos + P_WIDTH.
- facing = 0: kick_xpos = (xpos < KICK_W) ? 0 : xpos - KICK_W.
- kick_ypos = ypos + KICK_Y_OFF.
- kick_xpos and kick_ypos track movement during ACTIVE.
- kick_xpos and kick_ypos are meaningful only when kick_active = 1, but they are always driven.

Simultaneous events:
- Move, jump and kick on the same tick are all processed independently.
- rst mid-jump or mid-kick returns everything to the reset values immediately.

Test Plan:
1. Reset, then 5 frame_ticks with btn_right held -> xpos 100→120, facing = 1; ypos stays 380.
2. xpos = 2, btn_left for 1 tick -> xpos = 0, facing = 0; another tick -> xpos stays 0. From xpos = 598, btn_right for 1 tick -> xpos = 600, then holds at 600.
3. btn_jump pulse in GROUND -> tick 1: RISE with ypos 380. ypos falls 6 per tick to 260 on tick 21 (the apex clamp); FALL then returns to 380 by tick 41, state GROUND. btn_jump pressed mid-air has no effect.
4. btn_kick held for 30 frames -> kick_active = 1 for exactly 8 frames; no retrigger during COOLDOWN or after it. Release, then press at frame 30 -> new kick. Press at frame 10 (in COOLDOWN) -> ignored.
5. facing = 0 at xpos = 10 during a kick -> kick_xpos = 0. facing = 1 at xpos = 100, ypos = 380 -> kick_xpos = 140, kick_ypos = 420.
6. Assert rst mid-RISE with a kick ACTIVE (async, between clk edges) -> outputs return to 100/380, kick_active = 0 immediately. frame_tick held 0 -> no output changes for 1000 clks.
